mic_channel_select: RTL and testbench
=====================================

Name: mic_channel_select

Overview:
- Pushbutton-driven selector for the microphone channel index (0..NUM_CH-1) shown on the 2-digit HEX display.
- Synchronises and debounces two active-low keys, steps an up/down counter with wrap, and supports a direct load.
- The registered 5-bit channel output feeds the 2-digit display decoder and the channel mux in the mic array test top level.

Parameters:
- NUM_CH, 32: number of selectable channels, range 2..32; channel wraps within 0..NUM_CH-1.
- INIT_CH, 0: channel value after reset; must be < NUM_CH.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required to accept a key level change; min 2.
- REPEAT_DELAY, 25000000: held cycles before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 5000000: cycles between auto-repeat steps (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset_n  input  1  synchronous active-low reset.
- key_up_n  input  1  asynchronous pushbutton, low = pressed, increments.
- key_dn_n  input  1  asynchronous pushbutton, low = pressed, decrements.
- load_en  input  1  synchronous load strobe, high for one cycle.
- load_val  input  5  value to load; ignored when >= NUM_CH.
- channel  output  5  current channel index, registered.
- changed  output  1  one-cycle pulse, high in the same cycle channel takes a new value.

Behaviour:
- Reset (reset_n low at a clk edge):
  - channel = INIT_CH, changed = 0.
  - Sync FFs = 1 (released), debounced levels = released, debounce counters = 0, key FSMs = IDLE.
  - Reset mid-press: the key must be released and pressed again to step.
- Synchronisation: each key passes through a 2-FF synchroniser; only the second stage is used.
- Debounce (per key):
  - When the synced level differs from the debounced level, the counter increments; any sample that equals the debounced level clears it.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level toggles on that edge and the counter clears.
  - A press event is a debounced released->pressed transition (one cycle).
- Step: channel updates on the edge after the press event.
  - Total latency from the first edge sampling a held-low key: DEBOUNCE_CYCLES+3 edges.
  - Up: channel = (channel == NUM_CH-1) ? 0 : channel+1.
  - Down: channel = (channel == 0) ? NUM_CH-1 : channel-1.
- Simultaneous events:
  - Up and down step requests in the same cycle cancel: no change, changed = 0.
  - load_en with a valid load_val has priority over any step. channel = load_val next edge; changed = 1 only if load_val != channel.
  - load_en with load_val >= NUM_CH is ignored entirely; a coincident step still applies.
- Release produces no step.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.
- changed is 0 whenever channel does not change value.

Key FSM (per key): IDLE -> HELD on press event; HELD -> IDLE on debounced release. With AUTO_REPEAT_EN, HELD -> REPEAT after the delay described below.

Optional Feature:
- Macro: MIC_CHANNEL_SELECT_AUTO_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts REPEAT_DELAY cycles, then generates one step and enters REPEAT.
  - In REPEAT, one step every REPEAT_PERIOD cycles while held. Release returns to IDLE and clears the counter.
  - Repeat steps obey the same wrap, cancel and load-priority rules.
- Undefined: no repeat counters; a held key yields exactly one step.

Test Plan:
- Reset: reset_n=0 for 2 cycles with INIT_CH=5 -> channel=5, changed=0; key held low through reset release -> no step until release and re-press.
- Debounce (DEBOUNCE_CYCLES=4): key_up_n low for 3 cycles then high -> no change; low for 10 cycles -> channel 0->1 at edge 7, changed high exactly 1 cycle.
- Wrap (NUM_CH=10): channel=9, press up -> 0; channel=0, press down -> 9; each with a changed pulse.
- Simultaneous: both keys pressed on the same cycle -> channel unchanged, changed=0. load_en=1, load_val=17 coincident with an up event at channel 3 (NUM_CH=32) -> channel=17. load_val=31 with NUM_CH=20 -> ignored.
- Auto-repeat (macro defined, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8): hold up for 60 cycles from channel 0 -> steps at press+1, +20, +28, +36, +44, +52 -> channel 6; macro undefined -> channel 1.

Source files
------------

// File: rtl/mic_channel_select.sv
// Pushbutton channel selector: 2-FF sync, debounce, up/down wrap counter, direct load.
// Optional auto-repeat on held keys when MIC_CHANNEL_SELECT_AUTO_REPEAT_EN is defined.
module mic_channel_select #(
  parameter int NUM_CH          = 32,
  parameter int INIT_CH         = 0,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       load_en,
  input  logic [4:0] load_val,
  output logic [4:0] channel,
  output logic       changed
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] CH_MAX  = 5'(NUM_CH - 1);
  localparam logic [4:0] CH_INIT = 5'(INIT_CH);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} key_state_t;

  logic [1:0] key_raw;
  logic [1:0] step_req;
  logic [1:0] settle;
  logic       load_ok;
  logic [4:0] ch_nx;

  assign key_raw = {key_dn_n, key_up_n};

  // Keys are only armed once a released level is seen after the synchronisers
  // have flushed their reset value, so a key held through reset cannot step.
  always_ff @(posedge clk) begin
    if (!reset_n) settle <= 2'd0;
    else if (settle != 2'd2) settle <= settle + 2'd1;
  end

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic          sync1, sync2, deb_n, press_q, armed, req;
    logic [DW-1:0] db_cnt;
    key_state_t    state, state_nx;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        deb_n   <= 1'b1;
        db_cnt  <= '0;
        press_q <= 1'b0;
        armed   <= 1'b0;
      end else begin
        sync1   <= key_raw[k];
        sync2   <= sync1;
        press_q <= 1'b0;
        if (sync2 == deb_n) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          deb_n   <= sync2;
          db_cnt  <= '0;
          press_q <= ~sync2 & armed;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
        if (settle == 2'd2 && sync2) armed <= 1'b1;
      end
    end

`ifdef MIC_CHANNEL_SELECT_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
    logic [RW-1:0] rpt_cnt, rpt_cnt_nx;

    always_ff @(posedge clk) begin
      if (!reset_n) rpt_cnt <= '0;
      else          rpt_cnt <= rpt_cnt_nx;
    end
`endif

    always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
    end

    always_comb begin
      state_nx = state;
      req      = 1'b0;
`ifdef MIC_CHANNEL_SELECT_AUTO_REPEAT_EN
      rpt_cnt_nx = (state == IDLE) ? '0 : rpt_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (press_q) begin
            state_nx = HELD;
            req      = 1'b1;
          end
        end
        HELD, REPEAT: begin
          if (deb_n) begin
            state_nx = IDLE;
`ifdef MIC_CHANNEL_SELECT_AUTO_REPEAT_EN
            rpt_cnt_nx = '0;
          end else if (rpt_cnt == ((state == HELD) ? RD_LAST : RP_LAST)) begin
            state_nx   = REPEAT;
            req        = 1'b1;
            rpt_cnt_nx = '0;
`endif
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    assign step_req[k] = req;
  end

  assign load_ok = load_en && ({1'b0, load_val} < 6'(NUM_CH));

  // A valid load beats any step; opposing steps in the same cycle cancel.
  always_comb begin
    ch_nx = channel;
    if (load_ok)
      ch_nx = load_val;
    else if (step_req[0] && !step_req[1])
      ch_nx = (channel == CH_MAX) ? 5'd0 : channel + 5'd1;
    else if (step_req[1] && !step_req[0])
      ch_nx = (channel == 5'd0) ? CH_MAX : channel - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      channel <= CH_INIT;
      changed <= 1'b0;
    end else begin
      channel <= ch_nx;
      changed <= (ch_nx != channel);
    end
  end

endmodule

// File: tb/tb_mic_channel_select.sv
// Scoreboard bench for mic_channel_select: stimulus tasks push expected {cycle, channel}
// entries, an independent monitor pops them whenever changed pulses.
module tb_mic_channel_select;
  localparam int NUM_CH = 20;
  localparam int INIT_CH = 5;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_up_n, key_dn_n, load_en;
  logic [4:0] load_val;
  logic [4:0] channel;
  logic       changed;

  mic_channel_select #(
    .NUM_CH(NUM_CH), .INIT_CH(INIT_CH), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
    .load_en(load_en), .load_val(load_val), .channel(channel), .changed(changed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; int val; } exp_t;
  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   mch;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every changed pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && changed === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: changed pulse with channel %0d, none expected (cycle %0d)", channel, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_value", int'(channel), e.val);
        chk("sb_cycle", cyc, e.t);
      end
    end
  end

  function automatic int nxt(input int c, input bit up);
    if (up) return (c == NUM_CH - 1) ? 0 : c + 1;
    return (c == 0) ? NUM_CH - 1 : c - 1;
  endfunction

  // A press sampled low from edge c+1 is debounced after D samples past the
  // two sync stages, and the step lands D+3 edges in; release is debounced
  // at edge c+hold+2+D, the last edge a repeat step can still land on.
  task automatic press(input bit up, input bit dn, input int hold);
    int c;
    c = cyc;
    if (hold >= D && (up ^ dn)) begin
      mch = nxt(mch, up);
      q.push_back('{c + D + 3, mch});
`ifdef MIC_CHANNEL_SELECT_AUTO_REPEAT_EN
      for (int t = c + D + 3 + RD; t <= c + hold + 2 + D; t += RP) begin
        mch = nxt(mch, up);
        q.push_back('{t, mch});
      end
`endif
    end
    key_up_n = !up;
    key_dn_n = !dn;
    repeat (hold) @(negedge clk);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    repeat (D + 8) @(negedge clk);
    chk("chan_after_press", int'(channel), mch);
  endtask

  task automatic do_load(input int v);
    int c;
    c = cyc;
    if (v < NUM_CH) begin
      if (v != mch) q.push_back('{c + 1, v});
      mch = v;
    end
    load_en  = 1'b1;
    load_val = 5'(v);
    @(negedge clk);
    load_en  = 1'b0;
    load_val = 5'd0;
    repeat (3) @(negedge clk);
    chk("chan_after_load", int'(channel), mch);
  endtask

  // Load strobe lands exactly on the edge the up-step would take effect.
  task automatic coin(input int v);
    int c;
    c = cyc;
    if (v < NUM_CH) begin
      if (v != mch) q.push_back('{c + D + 3, v});
      mch = v;
    end else begin
      mch = nxt(mch, 1'b1);
      q.push_back('{c + D + 3, mch});
    end
    key_up_n = 1'b0;
    repeat (D + 2) @(negedge clk);
    load_en  = 1'b1;
    load_val = 5'(v);
    @(negedge clk);
    load_en  = 1'b0;
    load_val = 5'd0;
    key_up_n = 1'b1;
    repeat (D + 8) @(negedge clk);
    chk("chan_after_coincident", int'(channel), mch);
  endtask

  initial begin
    reset_n  = 1'b0;
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    load_en  = 1'b0;
    load_val = 5'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mch = INIT_CH;
    chk("reset_channel", int'(channel), INIT_CH);
    chk("reset_changed", int'(changed), 0);
    repeat (4) @(negedge clk);

    press(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 10);

    do_load(NUM_CH - 1);
    press(1'b1, 1'b0, 8);
    chk("wrap_up", int'(channel), 0);
    press(1'b0, 1'b1, 8);
    chk("wrap_dn", int'(channel), NUM_CH - 1);

    press(1'b1, 1'b1, 10);

    do_load(3);
    coin(17);
    do_load(31);
    coin(31);

    // Key held through reset must not step until released and pressed again.
    key_up_n = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mch = INIT_CH;
    repeat (20) @(negedge clk);
    chk("held_through_reset", int'(channel), INIT_CH);
    key_up_n = 1'b1;
    repeat (12) @(negedge clk);
    press(1'b1, 1'b0, 10);

    do_load(0);
    press(1'b1, 1'b0, 60);
`ifdef MIC_CHANNEL_SELECT_AUTO_REPEAT_EN
    chk("hold_60", int'(channel), 6);
`else
    chk("hold_60", int'(channel), 1);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: press(1'b1, 1'b0, $urandom_range(1, 30));
        1: press(1'b0, 1'b1, $urandom_range(1, 30));
        2: press(1'b1, 1'b1, $urandom_range(1, 12));
        3: do_load($urandom_range(0, 31));
        default: coin($urandom_range(0, 31));
      endcase
    end

    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
